serial_adder: RTL and testbench



---
 rtl/serial_adder.sv | 156 +++++++++++++++
 tb/tb_serial_adder.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// -----------------------------------------------------------------------------
// serial_adder
//
// Bit-serial 8-bit adder with carry-in. A single full-adder cell is reused over
// eight clock cycles, LSB first. A start/busy/done handshake frames each
// operation, and the registered result is held until the next one completes.
//
// Optional feature (compile-time macro):
//   SERIAL_ADDER_OVF_EN  adds the ovf output (signed overflow of the sum).
//
// Ports:
//   clk    in   1  rising-edge clock
//   rst_n  in   1  asynchronous active-low reset
//   start  in   1  operation request, accepted in IDLE or DONE
//   x      in   8  augend, sampled on the accepting edge
//   y      in   8  addend, sampled on the accepting edge
//   c_in   in   1  carry-in, sampled on the accepting edge
//   busy   out  1  high while the bit loop runs
//   done   out  1  one-cycle pulse when out/c_out are newly valid
//   out    out  8  (x + y + c_in) mod 256, held until the next completion
//   c_out  out  1  carry out of bit 7, held with out
//   ovf    out  1  signed overflow, held with out (SERIAL_ADDER_OVF_EN only)
// -----------------------------------------------------------------------------
module serial_adder (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] x,
  input  logic [7:0] y,
  input  logic       c_in,
  output logic       busy,
  output logic       done,
  output logic [7:0] out,
  output logic       c_out
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic       ovf
`endif
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0] state_q, state_d;
  logic [7:0] a_q, a_d;
  logic [7:0] b_q, b_d;
  logic [7:0] p_q, p_d;
  logic       c_q, c_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] out_q, out_d;
  logic       c_out_q, c_out_d;
`ifdef SERIAL_ADDER_OVF_EN
  logic       ovf_q, ovf_d;
`endif

  // Full-adder cell working on the current LSBs and the running carry.
  logic sum_bit;
  logic carry_next;

  always_comb begin
    sum_bit    = a_q[0] ^ b_q[0] ^ c_q;
    carry_next = (a_q[0] & b_q[0]) | (a_q[0] & c_q) | (b_q[0] & c_q);
  end

  always_comb begin
    // NOTE: every signal gets a hold default first so no path leaves it
    // unassigned; otherwise a latch would be inferred.
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    p_d     = p_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    c_out_d = c_out_q;
`ifdef SERIAL_ADDER_OVF_EN
    ovf_d   = ovf_q;
`endif

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          a_d     = x;
          b_d     = y;
          c_d     = c_in;
          cnt_d   = 3'd0;
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_RUN: begin
        a_d   = {1'b0, a_q[7:1]};
        b_d   = {1'b0, b_q[7:1]};
        c_d   = carry_next;
        p_d   = {sum_bit, p_q[7:1]};
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          // The last sum bit goes straight to out together with the seven
          // already shifted, so partial sums never appear on out.
          out_d   = {sum_bit, p_q[7:1]};
          c_out_d = carry_next;
`ifdef SERIAL_ADDER_OVF_EN
          // c_q is still the carry into bit 7 on this edge.
          ovf_d   = c_q ^ carry_next;
`endif
          state_d = ST_DONE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      p_q     <= '0;
      c_q     <= 1'b0;
      cnt_q   <= '0;
      out_q   <= '0;
      c_out_q <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      p_q     <= p_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      c_out_q <= c_out_d;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  // Status outputs decode the state flops only; no input reaches an output.
  assign busy  = (state_q == ST_RUN);
  assign done  = (state_q == ST_DONE);
  assign out   = out_q;
  assign c_out = c_out_q;
`ifdef SERIAL_ADDER_OVF_EN
  assign ovf   = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// -----------------------------------------------------------------------------
// tb_serial_adder
//
// Self-checking bench for serial_adder. Expected results come from plain
// 9-bit arithmetic on the operands; signed overflow from the sign rule.
// -----------------------------------------------------------------------------
module tb_serial_adder;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] x;
  logic [7:0] y;
  logic       c_in;
  logic       busy;
  logic       done;
  logic [7:0] out;
  logic       c_out;
`ifdef SERIAL_ADDER_OVF_EN
  logic       ovf;
`endif

  int checks;
  int failures;

  serial_adder dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .x     (x),
    .y     (y),
    .c_in  (c_in),
    .busy  (busy),
    .done  (done),
    .out   (out),
    .c_out (c_out)
`ifdef SERIAL_ADDER_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: exact 9-bit sum and signed overflow from operand signs.
  function automatic logic [8:0] ref_sum(input logic [7:0] xa, input logic [7:0] ya,
                                         input logic ca);
    return {1'b0, xa} + {1'b0, ya} + {8'd0, ca};
  endfunction

  function automatic logic ref_ovf(input logic [7:0] xa, input logic [7:0] ya,
                                   input logic ca);
    logic [8:0] s;
    s = ref_sum(xa, ya, ca);
    return (xa[7] == ya[7]) && (s[7] != xa[7]);
  endfunction

  // Wait (from a negedge) until done is seen high; returns negedges waited.
  task automatic wait_done(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!done && cyc < 20);
  endtask

  // Starts one operation from a negedge and checks the full handshake.
  task automatic run_op(input logic [7:0] xa, input logic [7:0] ya, input logic ca,
                        input string tag);
    logic [8:0] exp_s;
    int cyc;
    exp_s = ref_sum(xa, ya, ca);
    start = 1'b1; x = xa; y = ya; c_in = ca;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; x = 8'($urandom); y = 8'($urandom); c_in = 1'($urandom);
    check({tag, ".busy_run"}, 32'(busy), 32'd1);
    cyc = 1;
    while (!done && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, ".latency"}, 32'(cyc), 32'd9);
    check({tag, ".out"}, 32'(out), 32'(exp_s[7:0]));
    check({tag, ".c_out"}, 32'(c_out), 32'(exp_s[8]));
`ifdef SERIAL_ADDER_OVF_EN
    check({tag, ".ovf"}, 32'(ovf), 32'(ref_ovf(xa, ya, ca)));
`endif
    check({tag, ".busy_done"}, 32'(busy), 32'd0);
    @(negedge clk);
    check({tag, ".done_pulse"}, 32'(done), 32'd0);
    check({tag, ".out_hold"}, 32'(out), 32'(exp_s[7:0]));
  endtask

  initial begin
    int cyc;
    int n_done;
    logic [7:0] rx, ry;
    logic rc;

    checks   = 0;
    failures = 0;
    rst_n = 1'b0; start = 1'b0; x = 8'h00; y = 8'h00; c_in = 1'b0;

    // Reset state.
    #1;
    check("rst.busy", 32'(busy), 32'd0);
    check("rst.done", 32'(done), 32'd0);
    check("rst.out", 32'(out), 32'd0);
    check("rst.c_out", 32'(c_out), 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
    check("rst.ovf", 32'(ovf), 32'd0);
`endif
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed vectors.
    run_op(8'h3C, 8'h5A, 1'b0, "v3c_5a");
    run_op(8'hFF, 8'h01, 1'b0, "vff_01");
    run_op(8'h7F, 8'h00, 1'b1, "v7f_00_c");
    run_op(8'hFF, 8'hFF, 1'b1, "vff_ff_c");
    run_op(8'h00, 8'h00, 1'b0, "v00_00");

    // Back-to-back with start held high.
    start = 1'b1; x = 8'h80; y = 8'h80; c_in = 1'b0;
    @(posedge clk);
    @(negedge clk);
    x = 8'h01; y = 8'h02; c_in = 1'b0;
    cyc = 1;
    while (!done && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check("b2b1.latency", 32'(cyc), 32'd9);
    check("b2b1.out", 32'(out), 32'h00);
    check("b2b1.c_out", 32'(c_out), 32'd1);
`ifdef SERIAL_ADDER_OVF_EN
    check("b2b1.ovf", 32'(ovf), 32'd1);
`endif
    wait_done(cyc);
    start = 1'b0;
    check("b2b2.spacing", 32'(cyc), 32'd9);
    check("b2b2.out", 32'(out), 32'h03);
    check("b2b2.c_out", 32'(c_out), 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
    check("b2b2.ovf", 32'(ovf), 32'd0);
`endif
    @(negedge clk);
    @(negedge clk);

    // start pulsed during RUN must be ignored.
    start = 1'b1; x = 8'h21; y = 8'h42; c_in = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    start = 1'b1; x = 8'hFF; y = 8'hFF; c_in = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_done = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (done) n_done++;
    end
    check("ign.done_count", 32'(n_done), 32'd1);
    check("ign.out", 32'(out), 32'h64);
    check("ign.c_out", 32'(c_out), 32'd0);

    // Reset in the middle of RUN aborts the operation.
    start = 1'b1; x = 8'h10; y = 8'h20; c_in = 1'b0;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 3; i++) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort.busy", 32'(busy), 32'd0);
    check("abort.done", 32'(done), 32'd0);
    check("abort.out", 32'(out), 32'h00);
    @(negedge clk);
    rst_n = 1'b1;
    n_done = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done || busy) n_done++;
    end
    check("abort.no_done", 32'(n_done), 32'd0);
    run_op(8'h10, 8'h20, 1'b0, "after_abort");

    // Randomized operations against the arithmetic model.
    for (int i = 0; i < 24; i++) begin
      rx = 8'($urandom);
      ry = 8'($urandom);
      rc = 1'($urandom);
      run_op(rx, ry, rc, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
